// File: rtl/exanet_crosb_pkg.sv
// Shared types and width helpers for the crossbar egress VC credit scheduler.
package exanet_crosb_pkg;

    typedef enum logic {SCH_IDLE, SCH_BUSY} sched_state_t;

    function automatic int unsigned cred_w(input int unsigned credit_max);
        return $clog2(credit_max + 1);
    endfunction

endpackage

// File: rtl/exa_vc_credit_cnt.sv
// One downstream credit counter: saturating inc/dec with a sticky over/underflow flag.
module exa_vc_credit_cnt
    import exanet_crosb_pkg::*;
#(
    parameter int unsigned credit_max = 19,
    parameter int unsigned logCred    = cred_w(credit_max)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_inc,
    input  logic               i_dec,
    output logic [logCred-1:0] o_credit,
    output logic               o_zero,
    output logic               o_err
);

    localparam logic [logCred-1:0] CMAX = logCred'(credit_max);

    logic [logCred-1:0] credit_q, credit_d;
    logic               err_q, err_d;

    always_comb begin
        credit_d = credit_q;
        err_d    = err_q;
        // Simultaneous inc and dec cancel; only a lone event can over/underflow.
        if (i_inc && !i_dec) begin
            if (credit_q == CMAX) err_d = 1'b1;
            else                  credit_d = credit_q + 1'b1;
        end else if (i_dec && !i_inc) begin
            if (credit_q == '0) err_d = 1'b1;
            else                credit_d = credit_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_q <= CMAX;
            err_q    <= 1'b0;
        end else begin
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

    assign o_credit = credit_q;
    assign o_zero   = (credit_q == '0);
    assign o_err    = err_q;

endmodule

// File: rtl/exa_crosb_vc_credit_sched.sv
// Per-VC credit scheduler: strict priority across levels, round-robin within a level,
// grant held for a whole packet.
module exa_crosb_vc_credit_sched
    import exanet_crosb_pkg::*;
#(
    parameter int unsigned prio_num    = 2,
    parameter int unsigned vc_num      = 2,
    parameter int unsigned credit_max  = 19,
    parameter int unsigned min_credits = 1,
    parameter int unsigned logVcPrio   = $clog2(prio_num * vc_num),
    parameter int unsigned logCred     = cred_w(credit_max)
) (
    input  logic                         S_ACLK,
    input  logic                         S_ARESET,
    input  logic [prio_num*vc_num-1:0]   i_req,
    input  logic                         i_flit_fire,
    input  logic                         i_eop_fire,
    input  logic [prio_num*vc_num-1:0]   i_credit_ret,
    output logic                         o_grant_valid,
    output logic [logVcPrio-1:0]         o_grant_vc,
    output logic                         o_flit_allow,
    output logic [prio_num*vc_num-1:0]   o_credit_zero,
    output logic                         o_err
);

    localparam int unsigned NQ    = prio_num * vc_num;
    localparam int unsigned logVc = (vc_num > 1) ? $clog2(vc_num) : 1;

    sched_state_t                       state_q, state_d;
    logic [logVcPrio-1:0]               vc_q, vc_d;
    logic [prio_num-1:0][logVc-1:0]     rr_q, rr_d;
    logic                               err_q, err_d;

    logic [NQ-1:0]                      dec;
    logic [NQ-1:0]                      elig;
    logic [NQ-1:0]                      cnt_err;
    logic [NQ-1:0][logCred-1:0]         credit;

    logic                               win_any;
    logic [logVcPrio-1:0]               win_idx;
    logic                               lvl_found;
    logic [logVc-1:0]                   lvl_vc;

    for (genvar g = 0; g < NQ; g++) begin : g_cnt
        assign dec[g]  = i_flit_fire && (state_q == SCH_BUSY) && (vc_q == logVcPrio'(g));
        assign elig[g] = i_req[g] && (credit[g] >= logCred'(min_credits));

        exa_vc_credit_cnt #(
            .credit_max (credit_max),
            .logCred    (logCred)
        ) u_cnt (
            .clk      (S_ACLK),
            .rst      (S_ARESET),
            .i_inc    (i_credit_ret[g]),
            .i_dec    (dec[g]),
            .o_credit (credit[g]),
            .o_zero   (o_credit_zero[g]),
            .o_err    (cnt_err[g])
        );
    end

    // Levels scanned low to high so the highest eligible level overwrites the winner.
    always_comb begin
        win_any   = 1'b0;
        win_idx   = '0;
        lvl_found = 1'b0;
        lvl_vc    = '0;
        for (int unsigned p = 0; p < prio_num; p++) begin
            lvl_found = 1'b0;
            lvl_vc    = '0;
            for (int unsigned k = 0; k < vc_num; k++) begin
                if (!lvl_found && elig[p*vc_num + (32'(rr_q[p]) + k) % vc_num]) begin
                    lvl_found = 1'b1;
                    lvl_vc    = logVc'((32'(rr_q[p]) + k) % vc_num);
                end
            end
            if (lvl_found) begin
                win_any = 1'b1;
                win_idx = logVcPrio'(p*vc_num + 32'(lvl_vc));
            end
        end
    end

    always_comb begin
        state_d = state_q;
        vc_d    = vc_q;
        rr_d    = rr_q;
        err_d   = err_q;
        case (state_q)
            SCH_IDLE: begin
                if (i_flit_fire || i_eop_fire) begin
                    err_d = 1'b1;
                end else if (win_any) begin
                    vc_d    = win_idx;
                    state_d = SCH_BUSY;
                end
            end
            SCH_BUSY: begin
                if (i_eop_fire && !i_flit_fire) begin
                    err_d = 1'b1;
                end else if (i_flit_fire && i_eop_fire) begin
                    state_d = SCH_IDLE;
                    rr_d[32'(vc_q) / vc_num] = logVc'((32'(vc_q) % vc_num + 1) % vc_num);
                end
            end
            default: state_d = SCH_IDLE;
        endcase
    end

    always_ff @(posedge S_ACLK or posedge S_ARESET) begin
        if (S_ARESET) begin
            state_q <= SCH_IDLE;
            vc_q    <= '0;
            rr_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vc_q    <= vc_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
        end
    end

    assign o_grant_valid = (state_q == SCH_BUSY);
    assign o_grant_vc    = vc_q;
    assign o_flit_allow  = o_grant_valid && !o_credit_zero[vc_q];
    assign o_err         = err_q || (|cnt_err);

endmodule

// File: tb/tb_exa_crosb_vc_credit_sched.sv
// Directed bench for the VC credit scheduler with a queue-level reference model.
module tb_exa_crosb_vc_credit_sched;

    localparam int PN   = 2;
    localparam int VN   = 2;
    localparam int NQ   = PN * VN;
    localparam int CM   = 19;
    localparam int MINC = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NQ-1:0] i_req = '0;
    logic          i_flit_fire = 1'b0;
    logic          i_eop_fire = 1'b0;
    logic [NQ-1:0] i_credit_ret = '0;
    logic          o_grant_valid;
    logic [1:0]    o_grant_vc;
    logic          o_flit_allow;
    logic [NQ-1:0] o_credit_zero;
    logic          o_err;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_cred [NQ];
    int m_rr   [PN];
    bit m_busy;
    int m_vc;
    bit m_err;

    exa_crosb_vc_credit_sched #(
        .prio_num    (PN),
        .vc_num      (VN),
        .credit_max  (CM),
        .min_credits (MINC)
    ) dut (
        .S_ACLK        (clk),
        .S_ARESET      (rst),
        .i_req         (i_req),
        .i_flit_fire   (i_flit_fire),
        .i_eop_fire    (i_eop_fire),
        .i_credit_ret  (i_credit_ret),
        .o_grant_valid (o_grant_valid),
        .o_grant_vc    (o_grant_vc),
        .o_flit_allow  (o_flit_allow),
        .o_credit_zero (o_credit_zero),
        .o_err         (o_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick_winner();
        for (int p = PN - 1; p >= 0; p--)
            for (int k = 0; k < VN; k++) begin
                int q;
                q = p * VN + (m_rr[p] + k) % VN;
                if (i_req[q] && m_cred[q] >= MINC) return q;
            end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int q = 0; q < NQ; q++) m_cred[q] = CM;
            for (int p = 0; p < PN; p++) m_rr[p] = 0;
            m_busy = 0;
            m_vc   = 0;
            m_err  = 0;
        end else begin
            int w;
            int decq;
            w    = pick_winner();
            decq = (m_busy && i_flit_fire) ? m_vc : -1;
            for (int q = 0; q < NQ; q++) begin
                if (i_credit_ret[q] && q != decq) begin
                    if (m_cred[q] == CM) m_err = 1; else m_cred[q]++;
                end else if (!i_credit_ret[q] && q == decq) begin
                    if (m_cred[q] == 0) m_err = 1; else m_cred[q]--;
                end
            end
            if (!m_busy) begin
                if (i_flit_fire || i_eop_fire) m_err = 1;
                else if (w >= 0) begin
                    m_busy = 1;
                    m_vc   = w;
                end
            end else begin
                if (i_eop_fire && !i_flit_fire) m_err = 1;
                else if (i_flit_fire && i_eop_fire) begin
                    m_busy = 0;
                    m_rr[m_vc / VN] = (m_vc % VN + 1) % VN;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("grant_valid", int'(o_grant_valid), int'(m_busy));
        if (m_busy) begin
            check("grant_vc", int'(o_grant_vc), m_vc);
            check("flit_allow", int'(o_flit_allow), int'(m_cred[m_vc] != 0));
        end else begin
            check("flit_allow_idle", int'(o_flit_allow), 0);
        end
        for (int q = 0; q < NQ; q++)
            check($sformatf("credit_zero[%0d]", q), int'(o_credit_zero[q]), int'(m_cred[q] == 0));
        check("err", int'(o_err), int'(m_err));
    end

    task automatic step(input logic [NQ-1:0] req, input logic f, input logic e,
                        input logic [NQ-1:0] ret);
        i_req        = req;
        i_flit_fire  = f;
        i_eop_fire   = e;
        i_credit_ret = ret;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_req = '0; i_flit_fire = 1'b0; i_eop_fire = 1'b0; i_credit_ret = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        do_reset();

        // Reset state
        check("rst_valid", int'(o_grant_valid), 0);
        check("rst_err", int'(o_err), 0);
        check("rst_zero", int'(o_credit_zero), 0);
        for (int q = 0; q < NQ; q++) check("rst_model_cred", m_cred[q], 19);

        // Reset mid-packet drops the grant immediately
        step(4'b0001, 0, 0, '0);
        check("pre_rst_grant", int'(o_grant_valid), 1);
        step(4'b0001, 1, 0, '0);
        #2 rst = 1'b1;
        #1 check("async_rst_valid", int'(o_grant_valid), 0);
        check("async_rst_zero", int'(o_credit_zero), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        i_req = '0; i_flit_fire = 1'b0;
        check("post_rst_err", int'(o_err), 0);
        check("post_rst_cred0", m_cred[0], 19);

        // Round robin within prio1: 2,3,2,3 with an IDLE bubble between
        for (int n = 0; n < 4; n++) begin
            step(4'b1100, 0, 0, '0);
            check("rr_grant", int'(o_grant_vc), (n % 2 == 0) ? 2 : 3);
            step(4'b1100, 1, 1, '0);
            check("rr_bubble", int'(o_grant_valid), 0);
        end
        check("rr_cred2", m_cred[2], 17);
        check("rr_cred3", m_cred[3], 17);

        // Strict priority: q2 beats q0, then q0 once q2 drains
        step(4'b0101, 0, 0, '0);
        check("prio_grant", int'(o_grant_vc), 2);
        step(4'b0101, 1, 0, '0);
        step(4'b0101, 1, 0, '0);
        step(4'b0001, 1, 1, '0);
        check("prio_idle", int'(o_grant_valid), 0);
        check("prio_cred2", m_cred[2], 14);
        step(4'b0001, 0, 0, '0);
        check("prio_next", int'(o_grant_vc), 0);
        step(4'b0001, 1, 1, '0);

        // Credit gating on q1
        step(4'b0010, 0, 0, '0);
        check("cg_grant", int'(o_grant_vc), 1);
        for (int n = 0; n < 19; n++) step(4'b0010, 1, 0, '0);
        check("cg_allow0", int'(o_flit_allow), 0);
        check("cg_held", int'(o_grant_valid), 1);
        check("cg_zero", int'(o_credit_zero), 4'b0010);
        step(4'b0010, 0, 0, 4'b0010);
        check("cg_allow1", int'(o_flit_allow), 1);
        step(4'b0010, 1, 1, '0);
        step(4'b0010, 0, 0, '0);
        check("cg_nogrant", int'(o_grant_valid), 0);
        step(4'b0010, 0, 0, 4'b0010);
        check("cg_ret_same", int'(o_grant_valid), 0);
        step(4'b0010, 0, 0, '0);
        check("cg_ret_grant", int'(o_grant_valid), 1);
        check("cg_ret_vc", int'(o_grant_vc), 1);

        // Simultaneous fire and return leave credit unchanged
        step(4'b0010, 1, 0, 4'b0010);
        check("sim_cred1", m_cred[1], 1);
        check("sim_allow", int'(o_flit_allow), 1);
        step(4'b0000, 1, 1, '0);
        check("sim_err0", int'(o_err), 0);

        // Return at full credit saturates and flags
        check("sat_pre", m_cred[0], 18);
        step(4'b0000, 0, 0, 4'b0001);
        check("sat_err0", int'(o_err), 0);
        step(4'b0000, 0, 0, 4'b0001);
        check("sat_err1", int'(o_err), 1);
        check("sat_cred0", m_cred[0], 19);

        // Flit fire in IDLE
        do_reset();
        step(4'b0000, 1, 0, '0);
        check("idle_fire_err", int'(o_err), 1);
        check("idle_fire_valid", int'(o_grant_valid), 0);
        check("idle_fire_zero", int'(o_credit_zero), 0);
        for (int q = 0; q < NQ; q++) check("idle_fire_cred", m_cred[q], 19);
        step(4'b0000, 0, 0, '0);

        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
